// File: rtl/filter_cascade_param_if.sv
// Sample/coefficient bus of the filter cascade: the controller drives inputs
// (master), the filter returns the filtered sample and status (slave).
interface filter_cascade_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 10
);
  logic [COEF_W-1:0] coef_in;
  logic              coef_load;
  logic              clear_states;
  logic              start;
  logic [DATA_W-1:0] sig_in;
  logic [DATA_W-1:0] sig_out;
  logic              done;
  logic              busy;
  logic              sat_flag;
  logic [1:0]        dbg_state;

  modport master (
    output coef_in, coef_load, clear_states, start, sig_in,
    input  sig_out, done, busy, sat_flag, dbg_state
  );

  modport slave (
    input  coef_in, coef_load, clear_states, start, sig_in,
    output sig_out, done, busy, sat_flag, dbg_state
  );
endinterface

// File: rtl/filter_cascade_param.sv
// Cascade of NSECT all-pole biquad sections sharing one multiplier; each
// section takes two cycles (c1*s1 then c2*s2), one sample per start/done.
module filter_cascade_param #(
  parameter int NSECT     = 6,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 10,
  parameter int COEF_FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst_an,
  filter_cascade_param_if.slave   bus
);

  localparam int NSLOT  = 2 * NSECT;
  localparam int SW     = $clog2(NSLOT);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + ((COEF_W > COEF_FRAC) ? COEF_W : COEF_FRAC + 1) + 2;
  localparam logic [SW-1:0] LAST_BASE = SW'(NSLOT - 2);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(longint'(1) <<< (DATA_W - 1)));

  typedef enum logic [1:0] {IDLE = 2'd0, MAC1 = 2'd1, MAC2 = 2'd2, DONE = 2'd3} state_t;

  // Coefficients and states share one slot layout: slot 2k holds c1/s1 of
  // section k, slot 2k+1 holds c2/s2, so one index selects both operands.
  state_t                    state_q;
  logic [SW-1:0]             base_q;
  logic [SW-1:0]             ptr_q;
  logic signed [DATA_W-1:0]  x_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [COEF_W-1:0]  coef_q [NSLOT];
  logic signed [DATA_W-1:0]  st_q   [NSLOT];
  logic signed [DATA_W-1:0]  sig_out_q;
  logic                      done_q;
  logic                      busy_q;
  logic                      sat_q;

  logic [SW-1:0]             sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [DATA_W-1:0]  w;
  logic                      sat_hit;

  always_comb begin
    sel      = (state_q == MAC2) ? base_q + SW'(1) : base_q;
    prod     = PROD_W'(coef_q[sel]) * PROD_W'(st_q[sel]);
    acc_base = (state_q == MAC1) ? (ACC_W'(x_q) <<< COEF_FRAC) : acc_q;
    acc_sum  = acc_base + ACC_W'(prod);
    acc_shr  = acc_sum >>> COEF_FRAC;
    sat_hit  = 1'b0;
    w        = acc_shr[DATA_W-1:0];
    if (acc_shr > SAT_MAX) begin
      w       = SAT_MAX[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (acc_shr < SAT_MIN) begin
      w       = SAT_MIN[DATA_W-1:0];
      sat_hit = 1'b1;
    end
  end

  // Handshake: start is accepted only in IDLE (sig_in latched on that edge);
  // done pulses for one cycle when sig_out has been updated, busy covers MAC1/MAC2.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q   <= IDLE;
      base_q    <= '0;
      ptr_q     <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      sig_out_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        coef_q[i] <= '0;
        st_q[i]   <= '0;
      end
    end else begin
      if (!bus.coef_load) ptr_q <= '0;
      if (bus.clear_states) begin
        for (int i = 0; i < NSLOT; i++) st_q[i] <= '0;
        sat_q   <= 1'b0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        ptr_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            done_q <= 1'b0;
            if (bus.coef_load) begin
              coef_q[ptr_q] <= bus.coef_in;
              ptr_q         <= (ptr_q == LAST_SLOT) ? '0 : ptr_q + SW'(1);
            end else if (bus.start) begin
              x_q     <= bus.sig_in;
              base_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= MAC1;
            end
          end
          MAC1: begin
            acc_q   <= acc_sum;
            state_q <= MAC2;
          end
          MAC2: begin
            st_q[sel]    <= st_q[base_q];
            st_q[base_q] <= w;
            x_q          <= w;
            if (sat_hit) sat_q <= 1'b1;
            if (base_q == LAST_BASE) begin
              sig_out_q <= w;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= DONE;
            end else begin
              base_q  <= base_q + SW'(2);
              state_q <= MAC1;
            end
          end
          DONE: begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sig_out   = sig_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.sat_flag  = sat_q;
  assign bus.dbg_state = state_q;

endmodule
